// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if
//   Bundles the hazard-detection inputs and the pipeline-register controls
//   exchanged between the LEGv8 pipeline datapath and pipeline_hazard_ctrl.
//
//   Pipeline -> controller:
//     idex_memread, idex_wr    load in ID/EX and its destination register
//     ifid_rn, ifid_rm         source registers of the instruction in IF/ID
//     ifid_uses_rm             IF/ID instruction actually reads rm
//     exmem_branch, exmem_zero branch resolution in MEM
//     mem_access, mem_ready    data-memory request / completion
//   Controller -> pipeline:
//     pc_en, ifid_en, idex_en, exmem_en        register load enables
//     ifid_flush, idex_flush, exmem_flush      load a bubble
//     state                                    RUN/STALL/FLUSH/MEM_WAIT
//     mem_timeout                              sticky memory-timeout flag
//
//   master: the pipeline/datapath side, which drives the hazard inputs.
//   slave:  the hazard controller, which drives the register controls.
interface pipeline_hazard_ctrl_if;
    logic       idex_memread;
    logic [4:0] idex_wr;
    logic [4:0] ifid_rn;
    logic [4:0] ifid_rm;
    logic       ifid_uses_rm;
    logic       exmem_branch;
    logic       exmem_zero;
    logic       mem_access;
    logic       mem_ready;

    logic       pc_en;
    logic       ifid_en;
    logic       idex_en;
    logic       exmem_en;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_flush;
    logic [1:0] state;
    logic       mem_timeout;

    modport master (
        output idex_memread, idex_wr, ifid_rn, ifid_rm, ifid_uses_rm,
               exmem_branch, exmem_zero, mem_access, mem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en,
               ifid_flush, idex_flush, exmem_flush, state, mem_timeout
    );

    modport slave (
        input  idex_memread, idex_wr, ifid_rn, ifid_rm, ifid_uses_rm,
               exmem_branch, exmem_zero, mem_access, mem_ready,
        output pc_en, ifid_en, idex_en, exmem_en,
               ifid_flush, idex_flush, exmem_flush, state, mem_timeout
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard sequencer for the LEGv8 5-stage pipeline. Drives the PC and the
//   IF/ID, ID/EX, EX/MEM register enables and bubble (flush) controls for
//   load-use hazards, taken branches resolved in MEM, and multi-cycle
//   data-memory accesses. Event priority: memory wait > branch > load-use.
//
//   Ports:
//     clock        system clock, rising edge
//     reset        asynchronous, active-high reset
//     hz           pipeline_hazard_ctrl_if.slave (hazard inputs, controls,
//                  state, mem_timeout)
//     stall_cnt    (HAZARD_PERF_EN) cycles a load-use stall was applied
//     flush_cnt    (HAZARD_PERF_EN) cycles a branch flush was applied
//     wait_cnt     (HAZARD_PERF_EN) cycles spent frozen on data memory
//
//   Optional feature: define HAZARD_PERF_EN to add the three saturating
//   32-bit performance counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int WAIT_W      = 8,
    parameter int XZR_IDX     = 31
) (
    input  logic                    clock,
    input  logic                    reset,
    pipeline_hazard_ctrl_if.slave   hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]             stall_cnt,
    output logic [31:0]             flush_cnt,
    output logic [31:0]             wait_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        FLUSH    = 2'd2,
        MEM_WAIT = 2'd3
    } state_t;

    localparam logic [4:0]        XZR      = 5'(XZR_IDX);
    localparam logic [WAIT_W-1:0] WAIT_TMO = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q;

    logic br_taken, lu_haz, mwait;
    logic act_lu, act_br;

    // Event decode. XZR reads as zero, so a load targeting it can never
    // feed a consumer.
    assign br_taken = hz.exmem_branch & hz.exmem_zero;
    assign lu_haz   = hz.idex_memread & (hz.idex_wr != XZR) &
                      ((hz.idex_wr == hz.ifid_rn) |
                       (hz.ifid_uses_rm & (hz.idex_wr == hz.ifid_rm)));
    assign mwait    = hz.mem_access & ~hz.mem_ready;

    // Next-state and control outputs.
    always_comb begin
        state_d        = RUN;
        wait_d         = '0;
        act_lu         = 1'b0;
        act_br         = 1'b0;
        hz.pc_en       = 1'b1;
        hz.ifid_en     = 1'b1;
        hz.idex_en     = 1'b1;
        hz.exmem_en    = 1'b1;
        hz.ifid_flush  = 1'b0;
        hz.idex_flush  = 1'b0;
        hz.exmem_flush = 1'b0;

        if (reset) begin
            // Hold every register and inject bubbles while reset is high.
            hz.pc_en       = 1'b0;
            hz.ifid_en     = 1'b0;
            hz.idex_en     = 1'b0;
            hz.exmem_en    = 1'b0;
            hz.ifid_flush  = 1'b1;
            hz.idex_flush  = 1'b1;
            hz.exmem_flush = 1'b1;
        end else if (mwait) begin
            // Freeze the whole pipeline; nothing advances, nothing is cleared.
            hz.pc_en    = 1'b0;
            hz.ifid_en  = 1'b0;
            hz.idex_en  = 1'b0;
            hz.exmem_en = 1'b0;
            state_d     = MEM_WAIT;
            wait_d      = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
        end else if (br_taken) begin
            // PC loads the target; the three younger instructions are squashed.
            hz.ifid_flush  = 1'b1;
            hz.idex_flush  = 1'b1;
            hz.exmem_flush = 1'b1;
            state_d        = FLUSH;
            act_br         = 1'b1;
        end else if (lu_haz && state_q != FLUSH) begin
            // In FLUSH the ID/EX register holds a bubble, so a load-use
            // match there is stale. Otherwise hold PC and IF/ID, bubble EX.
            hz.pc_en      = 1'b0;
            hz.ifid_en    = 1'b0;
            hz.idex_flush = 1'b1;
            state_d       = STALL;
            act_lu        = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == MEM_WAIT && wait_q == WAIT_TMO)
                timeout_q <= 1'b1;
        end
    end

    assign hz.state       = state_q;
    assign hz.mem_timeout = timeout_q;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            if (act_lu && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
            if (act_br && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
            if (mwait  && wait_cnt  != '1) wait_cnt  <= wait_cnt  + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pipeline_hazard_ctrl_if hz_if();

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt, wait_cnt;
`endif

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT(255),
        .WAIT_W     (8),
        .XZR_IDX    (31)
    ) dut (
        .clock(clock),
        .reset(reset),
        .hz   (hz_if)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt),
        .wait_cnt (wait_cnt)
`endif
    );

    typedef struct packed {
        logic       memread;
        logic [4:0] wr;
        logic [4:0] rn;
        logic [4:0] rm;
        logic       uses_rm;
        logic       branch;
        logic       zero;
        logic       access;
        logic       ready;
    } stim_t;

    // Expected-vector layout: {state[1:0], pc_en, ifid_en, idex_en, exmem_en,
    //                          ifid_flush, idex_flush, exmem_flush, mem_timeout}
    localparam logic [1:0] S_RUN = 2'd0, S_STALL = 2'd1, S_FLUSH = 2'd2, S_MW = 2'd3;
    localparam logic [6:0] C_DEF = 7'b1111_000;
    localparam logic [6:0] C_LU  = 7'b0011_010;
    localparam logic [6:0] C_BR  = 7'b1111_111;
    localparam logic [6:0] C_MW  = 7'b0000_000;
    localparam logic [6:0] C_RST = 7'b0000_111;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

    function automatic stim_t st(logic memread, logic [4:0] wr, logic [4:0] rn,
                                 logic [4:0] rm, logic uses_rm, logic branch,
                                 logic zero, logic access, logic ready);
        stim_t s;
        s = '{memread, wr, rn, rm, uses_rm, branch, zero, access, ready};
        return s;
    endfunction

    function automatic logic [9:0] observe();
        return {hz_if.state, hz_if.pc_en, hz_if.ifid_en, hz_if.idex_en, hz_if.exmem_en,
                hz_if.ifid_flush, hz_if.idex_flush, hz_if.exmem_flush, hz_if.mem_timeout};
    endfunction

    task automatic apply(input stim_t s);
        hz_if.idex_memread = s.memread;
        hz_if.idex_wr      = s.wr;
        hz_if.ifid_rn      = s.rn;
        hz_if.ifid_rm      = s.rm;
        hz_if.ifid_uses_rm = s.uses_rm;
        hz_if.exmem_branch = s.branch;
        hz_if.exmem_zero   = s.zero;
        hz_if.mem_access   = s.access;
        hz_if.mem_ready    = s.ready;
    endtask

    stim_t IDLE;

    task automatic test_reset();
        logic [9:0] got, want;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin #3; exp_q.push_back({S_RUN, C_RST, 1'b0}); end
                1: begin @(negedge clock); reset = 1'b0; apply(IDLE);
                         exp_q.push_back({S_RUN, C_DEF, 1'b0}); #2; end
                2: begin @(negedge clock); apply(st(1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, 0));
                         exp_q.push_back({S_RUN, C_LU, 1'b0}); #2; end
                3: begin @(posedge clock); #1; apply(IDLE);
                         exp_q.push_back({S_STALL, C_DEF, 1'b0}); #1; end
                4: begin reset = 1'b1;
                         exp_q.push_back({S_RUN, C_RST, 1'b0}); #1; end
                default: begin @(negedge clock); reset = 1'b0;
                         exp_q.push_back({S_RUN, C_DEF, 1'b0}); #2; end
            endcase
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset[%0d]: got %b required %b", i, got, want);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t s[7]; logic [9:0] e[7]; logic [9:0] got, want;
        s[0] = st(1, 5'd5, 5'd5, 5'd9, 0, 0, 0, 0, 0); e[0] = {S_RUN,   C_LU,  1'b0};
        s[1] = IDLE;                                   e[1] = {S_STALL, C_DEF, 1'b0};
        s[2] = IDLE;                                   e[2] = {S_RUN,   C_DEF, 1'b0};
        s[3] = st(1, 5'd7, 5'd2, 5'd7, 1, 0, 0, 0, 0); e[3] = {S_RUN,   C_LU,  1'b0};
        s[4] = st(1, 5'd7, 5'd7, 5'd1, 0, 0, 0, 0, 0); e[4] = {S_STALL, C_LU,  1'b0};
        s[5] = IDLE;                                   e[5] = {S_STALL, C_DEF, 1'b0};
        s[6] = IDLE;                                   e[6] = {S_RUN,   C_DEF, 1'b0};
        for (int i = 0; i < 7; i++) begin
            @(negedge clock); apply(s[i]); exp_q.push_back(e[i]); #2;
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL load_use[%0d]: got %b required %b", i, got, want);
            end
        end
    endtask

    task automatic test_no_hazard();
        stim_t s[4]; logic [9:0] e[4]; logic [9:0] got, want;
        s[0] = st(1, 5'd31, 5'd31, 5'd31, 1, 0, 0, 0, 0); e[0] = {S_RUN, C_DEF, 1'b0};
        s[1] = st(1, 5'd5,  5'd3,  5'd5,  0, 0, 0, 0, 0); e[1] = {S_RUN, C_DEF, 1'b0};
        s[2] = st(0, 5'd4,  5'd4,  5'd4,  1, 0, 0, 0, 0); e[2] = {S_RUN, C_DEF, 1'b0};
        s[3] = st(0, 5'd0,  5'd0,  5'd0,  0, 1, 0, 1, 1); e[3] = {S_RUN, C_DEF, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clock); apply(s[i]); exp_q.push_back(e[i]); #2;
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL no_hazard[%0d]: got %b required %b", i, got, want);
            end
        end
    endtask

    task automatic test_branch();
        stim_t s[3]; logic [9:0] e[3]; logic [9:0] got, want;
        // Branch wins over a simultaneous load-use; a load-use seen in FLUSH is ignored.
        s[0] = st(1, 5'd5, 5'd5, 5'd0, 0, 1, 1, 0, 0); e[0] = {S_RUN,   C_BR,  1'b0};
        s[1] = st(1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, 0); e[1] = {S_FLUSH, C_DEF, 1'b0};
        s[2] = IDLE;                                   e[2] = {S_RUN,   C_DEF, 1'b0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); apply(s[i]); exp_q.push_back(e[i]); #2;
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL branch[%0d]: got %b required %b", i, got, want);
            end
        end
    endtask

    task automatic test_mem_wait();
        stim_t s[9]; logic [9:0] e[9]; logic [9:0] got, want;
        s[0] = st(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0); e[0] = {S_RUN,   C_MW,  1'b0};
        s[1] = s[0];                                   e[1] = {S_MW,    C_MW,  1'b0};
        s[2] = s[0];                                   e[2] = {S_MW,    C_MW,  1'b0};
        s[3] = st(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1); e[3] = {S_MW,    C_DEF, 1'b0};
        s[4] = IDLE;                                   e[4] = {S_RUN,   C_DEF, 1'b0};
        // Memory wait outranks branch and load-use; branch acts on the ready cycle.
        s[5] = st(1, 5'd6, 5'd6, 5'd0, 0, 1, 1, 1, 0); e[5] = {S_RUN,   C_MW,  1'b0};
        s[6] = st(0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 1, 1); e[6] = {S_MW,    C_BR,  1'b0};
        s[7] = IDLE;                                   e[7] = {S_FLUSH, C_DEF, 1'b0};
        s[8] = IDLE;                                   e[8] = {S_RUN,   C_DEF, 1'b0};
        for (int i = 0; i < 9; i++) begin
            @(negedge clock); apply(s[i]); exp_q.push_back(e[i]); #2;
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL mem_wait[%0d]: got %b required %b", i, got, want);
            end
        end
    endtask

    task automatic test_timeout();
        logic [9:0] got, want;
        @(negedge clock); apply(IDLE); reset = 1'b1; #1; reset = 1'b0;
        for (int i = 0; i < 302; i++) begin
            @(negedge clock);
            if (i < 300) begin
                apply(st(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0));
                // Register counter equals i (saturating); the flag is captured
                // on the edge where the counter reads 255 in MEM_WAIT.
                exp_q.push_back({(i == 0) ? S_RUN : S_MW, C_MW, (i >= 256) ? 1'b1 : 1'b0});
            end else if (i == 300) begin
                apply(st(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1));
                exp_q.push_back({S_MW, C_DEF, 1'b1});
            end else begin
                apply(IDLE);
                exp_q.push_back({S_RUN, C_DEF, 1'b1});
            end
            #2;
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL timeout[%0d]: got %b required %b", i, got, want);
            end
`ifdef HAZARD_PERF_EN
            if (i == 300) begin
                checks++;
                if ({stall_cnt, flush_cnt, wait_cnt} !== {32'd0, 32'd0, 32'd300}) begin
                    errors++;
                    $display("FAIL perf_cnt: got stall=%0d flush=%0d wait=%0d required 0 0 300",
                             stall_cnt, flush_cnt, wait_cnt);
                end
            end
`endif
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        IDLE = '0;
        apply(IDLE);
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch();
        test_mem_wait();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequences the LEGv8 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM) and the PC.
- Generates per-register enable (hold) and flush (bubble) controls for three events:
  - load-use hazards;
  - taken branches resolved in MEM;
  - multi-cycle data-memory accesses.
- Sits beside the pipeline registers; it drives their write-enable and synchronous-clear inputs.

Parameters:
- MEM_TIMEOUT, 255: wait cycles after which mem_timeout is raised.
- WAIT_W, 8: width of the wait counter; must hold MEM_TIMEOUT.
- XZR_IDX, 31: register index that never creates a hazard.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- idex_memread  in  1  MemRead of the instruction in ID/EX.
- idex_wr  in  5  destination register of ID/EX.
- ifid_rn  in  5  first source register of the instruction in IF/ID.
- ifid_rm  in  5  second source register of IF/ID.
- ifid_uses_rm  in  1  IF/ID instruction reads rm (R-format, STUR, CBZ).
- exmem_branch  in  1  Branch_s4.
- exmem_zero  in  1  Zero_s4.
- mem_access  in  1  MemRead_s4 | MemWrite_s4.
- mem_ready  in  1  data memory completes this cycle.
- pc_en, ifid_en, idex_en, exmem_en  out  1 each  register load enables.
- ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble (all controls 0).
- state  out  2  RUN=0, STALL=1, FLUSH=2, MEM_WAIT=3.
- mem_timeout  out  1  sticky error flag.

Behaviour:
- State and wait counter are registered. Enables and flushes are combinational from the current state and inputs.
- Reset asserted (asynchronous):
  - state=RUN, counter=0, mem_timeout=0.
  - While reset is high: all *_en=0 and all *_flush=1.
- Default (no event): all *_en=1, all *_flush=0.
- Event definitions:
  - br_taken = exmem_branch & exmem_zero.
  - lu_haz = idex_memread & (idex_wr != XZR_IDX) & ((idex_wr == ifid_rn) | (ifid_uses_rm & (idex_wr == ifid_rm))).
  - mwait = mem_access & ~mem_ready.
- Priority (highest first): mwait > br_taken > lu_haz. Only the highest active event acts in a given cycle.
- mwait:
  - All four enables = 0, all flushes = 0 (whole pipeline frozen).
  - Next state = MEM_WAIT; counter increments, saturating at all ones.
- br_taken:
  - ifid_flush = idex_flush = exmem_flush = 1; pc_en = 1 (PC loads the branch target).
  - Next state = FLUSH.
- lu_haz:
  - pc_en = 0, ifid_en = 0, idex_flush = 1, exmem_en = 1.
  - Next state = STALL.
- STALL and FLUSH each last exactly one cycle, then return to RUN unless a new event occurs.
  - In FLUSH, lu_haz is ignored because ID/EX holds a bubble.
  - STALL may chain: a fresh lu_haz re-enters STALL.
- MEM_WAIT:
  - Stays in MEM_WAIT while mwait holds.
  - In the cycle mem_ready=1, the default enables apply (or br_taken handling, if active), the counter clears, and next state = RUN/FLUSH.
- mem_timeout is set when counter == MEM_TIMEOUT while in MEM_WAIT. It stays 1 until reset; it does not alter sequencing.
- Reset asserted mid-stall or mid-wait: state returns to RUN immediately and the counter clears.
- No combinational path from any *_en or *_flush output back into any input.

Optional Feature:
HAZARD_PERF_EN:
- Defined: adds three 32-bit outputs, stall_cnt, flush_cnt and wait_cnt.
  - Each counts cycles with lu_haz acted on, br_taken acted on, and mwait, respectively.
  - Counters saturate at 0xFFFFFFFF and clear on reset.
- Undefined: the three ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset pulse mid-cycle -> outputs immediately en=0 and flush=1. After release: state=0, all en=1, flush=0, mem_timeout=0.
- idex_memread=1, idex_wr=5, ifid_rn=5 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1; next cycle state=STALL, then RUN with defaults.
- idex_wr=31 with ifid_rn=31 and idex_memread=1 -> no stall; all en=1.
- Same with ifid_rm=5, ifid_uses_rm=0 (ifid_rn≠5) -> no stall.
- exmem_branch=1, exmem_zero=1 with lu_haz also true -> three flushes=1, pc_en=1, no stall; next state=FLUSH for exactly 1 cycle.
- mem_access=1, mem_ready=0 for 3 cycles, then ready -> all en=0 for 3 cycles with state=MEM_WAIT; on the ready cycle en=1; next state=RUN.
- Hold mem_ready=0 for 300 cycles with MEM_TIMEOUT=255 -> mem_timeout rises when the counter equals 255 and stays high after ready. With HAZARD_PERF_EN defined, wait_cnt=300.
